serial_bit_source: RTL and testbench

Parallel-to-serial stage that feeds the serial sequence-detector FSM input x. It accepts a DATA_W-bit word through a load/ready handshake and shifts it out MSB-first on x_out. Each bit is held for DIV clocks. With DIV=1 there is one bit per clk, so x_out connects directly to the detector's x. It also exposes status for the bench and the debug LEDs.

---
 rtl/serial_pkg.sv | 13 +
 rtl/bit_rate_tick.sv | 35 +++
 rtl/serial_bit_source.sv | 129 ++++++++++++
 tb/tb_serial_bit_source.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared state encoding for the serial bit source and anything that decodes its state_o.
package serial_pkg;

   localparam int unsigned StateW = 2;

   typedef enum logic [StateW-1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      PAR   = 2'b10,
      ERR   = 2'b11
   } state_t;

endpackage

// File: rtl/bit_rate_tick.sv
// Bit-period divider: marks the first and last clk of each DIV-clock bit slot.
module bit_rate_tick #(
   parameter int unsigned DIV = 1
) (
   input  logic clk,
   input  logic Reset,
   input  logic clear,
   output logic tick_first,
   output logic tick_last
);

   localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

   logic [CntW-1:0] div_cnt_q, div_cnt_d;

   always_comb begin
      div_cnt_d = div_cnt_q + 1'b1;
      if (clear || (div_cnt_q == CntMax)) begin
         div_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         div_cnt_q <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
      end
   end

   assign tick_first = (div_cnt_q == '0);
   assign tick_last  = (div_cnt_q == CntMax);

endmodule

// File: rtl/serial_bit_source.sv
// MSB-first parallel-to-serial source with load/ready handshake and back-to-back frames.
// Define SERIAL_BIT_SOURCE_PARITY_EN to append an even-parity bit to every frame.
module serial_bit_source
   import serial_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DIV    = 1
) (
   input  logic              clk,
   input  logic              Reset,
   input  logic [DATA_W-1:0] data_in,
   input  logic              load,
   output logic              ready,
   output logic              x_out,
   output logic              bit_strobe,
   output logic              busy,
   output logic [StateW-1:0] state_o
);

   localparam int unsigned BitW = $clog2(DATA_W);
   localparam logic [BitW-1:0] LastBit = BitW'(DATA_W - 1);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
   logic              tick_first, tick_last;
   logic              active, frame_end, accept;

`ifdef SERIAL_BIT_SOURCE_PARITY_EN
   logic par_q, par_d;

   assign active    = (state_q == SHIFT) || (state_q == PAR);
   assign frame_end = (state_q == PAR) && tick_last;
`else
   assign active    = (state_q == SHIFT);
   assign frame_end = (state_q == SHIFT) && tick_last && (bit_cnt_q == LastBit);
`endif

   // Divider is held at zero outside a frame so the first bit always gets a full slot.
   bit_rate_tick #(
      .DIV (DIV)
   ) u_tick (
      .clk        (clk),
      .Reset      (Reset),
      .clear      (~active),
      .tick_first (tick_first),
      .tick_last  (tick_last)
   );

   assign ready  = (state_q == IDLE) || frame_end;
   assign accept = load && ready;

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
      par_d     = par_q;
`endif
      case (state_q)
         IDLE: ;
         SHIFT: begin
            if (tick_last) begin
               shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == LastBit) begin
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
                  state_d = PAR;
`else
                  state_d = IDLE;
`endif
               end
            end
         end
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
         PAR: begin
            if (tick_last) begin
               state_d = IDLE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
      // A load in the final clk of a frame overrides the return to IDLE.
      if (accept) begin
         state_d   = SHIFT;
         shreg_d   = data_in;
         bit_cnt_d = '0;
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
         par_d     = ^data_in;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
         par_q     <= par_d;
`endif
      end
   end

   always_comb begin
      x_out = 1'b0;
      if (state_q == SHIFT) begin
         x_out = shreg_q[DATA_W-1];
      end
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
      if (state_q == PAR) begin
         x_out = par_q;
      end
`endif
   end

   assign bit_strobe = active && tick_first;
   assign busy       = active;
   assign state_o    = state_q;

endmodule

// File: tb/tb_serial_bit_source.sv
// Scoreboard bench: stimulus queues expected per-cycle outputs, monitors pop while frames run.
module tb_serial_bit_source;

   localparam int unsigned DataW = 8;
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
   localparam int ParBits = 1;
`else
   localparam int ParBits = 0;
`endif
   localparam logic [5:0] IdleRec = 6'b000001;  // {busy, state, x, strobe, ready}

   typedef logic [5:0] rec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [DataW-1:0] data_a = '0, data_b = '0;
   logic             load_a = 1'b0, load_b = 1'b0;
   logic             ready_a, x_a, strobe_a, busy_a;
   logic             ready_b, x_b, strobe_b, busy_b;
   logic [1:0]       state_a, state_b;

   rec_t q_a[$];
   rec_t q_b[$];
   rec_t exp_a, exp_b;
   int   checks = 0;
   int   errors = 0;

   serial_bit_source #(.DATA_W(DataW), .DIV(1)) u_dut_a (
      .clk        (clk),
      .Reset      (rst),
      .data_in    (data_a),
      .load       (load_a),
      .ready      (ready_a),
      .x_out      (x_a),
      .bit_strobe (strobe_a),
      .busy       (busy_a),
      .state_o    (state_a)
   );

   serial_bit_source #(.DATA_W(DataW), .DIV(3)) u_dut_b (
      .clk        (clk),
      .Reset      (rst),
      .data_in    (data_b),
      .load       (load_b),
      .ready      (ready_b),
      .x_out      (x_b),
      .bit_strobe (strobe_b),
      .busy       (busy_b),
      .state_o    (state_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic rec_t obs_a();
      return {busy_a, state_a, x_a, strobe_a, ready_a};
   endfunction

   function automatic rec_t obs_b();
      return {busy_b, state_b, x_b, strobe_b, ready_b};
   endfunction

   always @(negedge clk) begin
      if (busy_a || q_a.size() != 0) begin
         if (q_a.size() == 0) begin
            check("a_unexpected_bit", obs_a(), IdleRec);
         end else begin
            exp_a = q_a.pop_front();
            check("a_bit", obs_a(), exp_a);
         end
      end
   end

   always @(negedge clk) begin
      if (busy_b || q_b.size() != 0) begin
         if (q_b.size() == 0) begin
            check("b_unexpected_bit", obs_b(), IdleRec);
         end else begin
            exp_b = q_b.pop_front();
            check("b_bit", obs_b(), exp_b);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_frame(input bit to_b, input logic [DataW-1:0] w, input int div);
      int   nb;
      logic bv;
      logic [1:0] st;
      rec_t r;
      nb = DataW + ParBits;
      for (int i = 0; i < nb; i++) begin
         bv = (i < DataW) ? w[DataW-1-i] : ^w;
         st = (i < DataW) ? 2'b01 : 2'b10;
         for (int j = 0; j < div; j++) begin
            r = {1'b1, st, bv, (j == 0), ((i == nb - 1) && (j == div - 1))};
            if (to_b) q_b.push_back(r);
            else q_a.push_back(r);
         end
      end
   endtask

   task automatic start_a(input logic [DataW-1:0] w);
      load_a = 1'b1;
      data_a = w;
      tick();
      load_a = 1'b0;
      push_frame(1'b0, w, 1);
   endtask

   task automatic wait_idle(input bit on_b, input string name);
      int n = 0;
      while ((on_b ? (q_b.size() != 0 || busy_b) : (q_a.size() != 0 || busy_a)) && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) begin
         check({name, "_timeout"}, n, 0);
      end
      check({name, "_idle"}, on_b ? obs_b() : obs_a(), IdleRec);
   endtask

   initial begin
      int n;
      int s;
      // Reset state
      tick();
      tick();
      check("a_reset", obs_a(), IdleRec);
      check("b_reset", obs_b(), IdleRec);

      // Reset wins over a simultaneous load
      load_a = 1'b1;
      data_a = 8'h93;
      tick();
      check("a_reset_vs_load", obs_a(), IdleRec);
      load_a = 1'b0;
      rst = 1'b0;
      tick();
      check("a_after_reset_load", obs_a(), IdleRec);

      // Basic frame
      start_a(8'h93);
      wait_idle(1'b0, "a_93");

      // Back-to-back frames
      start_a(8'hF0);
      n = 0;
      while (!ready_a && n < 50) begin
         tick();
         n++;
      end
      check("a_ready_rise_cycles", n, DataW + ParBits - 1);
      load_a = 1'b1;
      data_a = 8'h0F;
      tick();
      load_a = 1'b0;
      push_frame(1'b0, 8'h0F, 1);
      wait_idle(1'b0, "a_b2b");

      // Loads during a frame are ignored
      start_a(8'h81);
      tick();
      load_a = 1'b1;
      data_a = 8'hFF;
      repeat (5) tick();
      load_a = 1'b0;
      wait_idle(1'b0, "a_ignore");

      // Reset mid-frame
      start_a(8'hAA);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      q_a.delete();
      check("a_midreset", obs_a(), IdleRec);
      rst = 1'b0;
      s = 0;
      repeat (12) begin
         tick();
         if (strobe_a || busy_a || x_a) s++;
      end
      check("a_quiet_after_reset", s, 0);

      // Slow bit rate
      load_b = 1'b1;
      data_b = 8'hC5;
      tick();
      load_b = 1'b0;
      push_frame(1'b1, 8'hC5, 3);
      wait_idle(1'b1, "b_c5");

      // Parity-sensitive frame on the fast instance
      start_a(8'h07);
      wait_idle(1'b0, "a_07");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
